// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the execute stage: ALU opcodes, branch funct3,
// forwarding selects and writeback-source encodings.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Select 11 falls back to the register-file operand.
    function automatic logic [XLEN-1:0] fwd_select(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        logic [XLEN-1:0] val;
        case (sel)
            FWD_WB:  val = wb_val;
            FWD_MEM: val = mem_val;
            default: val = rf_val;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs, hazard-unit controls, fetch redirect and EX/MEM outputs of
// the execute stage, bundled as one interface.
interface execute_stage_if;
    import rv32_pkg::*;

    logic            RegWriteE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic            ALUSrcE;
    logic            JalrE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCPlus4E;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [4:0]      RdE;
    logic [1:0]      ForwardAE;
    logic [1:0]      ForwardBE;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;

    logic            RegWriteM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] ALUResultM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic [4:0]      RdM;
    logic [2:0]      funct3M;

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE,
               ResultSrcE, ALUControlE, funct3E, PCE, ImmExtE, PCPlus4E,
               RD1E, RD2E, RdE, ForwardAE, ForwardBE, ResultW, FlushE,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RdM, funct3M
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE,
               ResultSrcE, ALUControlE, funct3E, PCE, ImmExtE, PCPlus4E,
               RD1E, RD2E, RdE, ForwardAE, ForwardBE, ResultW, FlushE,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               ALUResultM, WriteDataM, PCPlus4M, RdM, funct3M
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU; unknown opcodes produce zero, shifts use the low
// five bits of src_b.
module alu
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = src_b[4:0];

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:   result = src_a + src_b;
            ALU_SUB:   result = src_a - src_b;
            ALU_AND:   result = src_a & src_b;
            ALU_OR:    result = src_a | src_b;
            ALU_XOR:   result = src_a ^ src_b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_SLL:   result = src_a << shamt;
            ALU_SRL:   result = src_a >> shamt;
            ALU_SRA:   result = $unsigned($signed(src_a) >>> shamt);
            ALU_PASSB: result = src_b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register. EX_PERF_CNT_EN adds three event counters.
module execute_stage
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  ex
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]     InstrCntE,
    output logic [31:0]     BranchCntE,
    output logic [31:0]     TakenCntE
`endif
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            taken;
    logic            pc_src;
    logic [XLEN-1:0] pc_target;

    logic            reg_write_m_d,   reg_write_m_q;
    logic            mem_write_m_d,   mem_write_m_q;
    logic [1:0]      result_src_m_d,  result_src_m_q;
    logic [XLEN-1:0] alu_result_m_d,  alu_result_m_q;
    logic [XLEN-1:0] write_data_m_d,  write_data_m_q;
    logic [XLEN-1:0] pc_plus4_m_d,    pc_plus4_m_q;
    logic [4:0]      rd_m_d,          rd_m_q;
    logic [2:0]      funct3_m_d,      funct3_m_q;

    // The MEM-stage forward comes from our own register, not an external port.
    assign src_a = fwd_select(ex.ForwardAE, ex.RD1E, ex.ResultW, alu_result_m_q);
    assign fwd_b = fwd_select(ex.ForwardBE, ex.RD2E, ex.ResultW, alu_result_m_q);
    assign src_b = ex.ALUSrcE ? ex.ImmExtE : fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .src_a       (src_a),
        .src_b       (src_b),
        .alu_control (ex.ALUControlE),
        .result      (alu_result)
    );

    // Branch compare always uses the forwarded rs2, never the immediate.
    always_comb begin
        taken = 1'b0;
        case (ex.funct3E)
            F3_BEQ:  taken = (src_a == fwd_b);
            F3_BNE:  taken = (src_a != fwd_b);
            F3_BLT:  taken = ($signed(src_a) <  $signed(fwd_b));
            F3_BGE:  taken = ($signed(src_a) >= $signed(fwd_b));
            F3_BLTU: taken = (src_a <  fwd_b);
            F3_BGEU: taken = (src_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_target = ex.JalrE ? ((src_a + ex.ImmExtE) & ~{{(XLEN-1){1'b0}}, 1'b1})
                                : (ex.PCE + ex.ImmExtE);
    assign pc_src    = !ex.FlushE && ((ex.BranchE && taken) || ex.JumpE);

    assign ex.PCSrcE    = pc_src;
    assign ex.PCTargetE = pc_target;

    always_comb begin
        reg_write_m_d  = ex.RegWriteE & ~ex.FlushE;
        mem_write_m_d  = ex.MemWriteE & ~ex.FlushE;
        result_src_m_d = ex.ResultSrcE;
        alu_result_m_d = alu_result;
        write_data_m_d = fwd_b;
        pc_plus4_m_d   = ex.PCPlus4E;
        rd_m_d         = ex.RdE;
        funct3_m_d     = ex.funct3E;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
            funct3_m_q     <= '0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            rd_m_q         <= rd_m_d;
            funct3_m_q     <= funct3_m_d;
        end
    end

    assign ex.RegWriteM  = reg_write_m_q;
    assign ex.MemWriteM  = mem_write_m_q;
    assign ex.ResultSrcM = result_src_m_q;
    assign ex.ALUResultM = alu_result_m_q;
    assign ex.WriteDataM = write_data_m_q;
    assign ex.PCPlus4M   = pc_plus4_m_q;
    assign ex.RdM        = rd_m_q;
    assign ex.funct3M    = funct3_m_q;

`ifdef EX_PERF_CNT_EN
    logic [31:0] instr_cnt_d,  instr_cnt_q;
    logic [31:0] branch_cnt_d, branch_cnt_q;
    logic [31:0] taken_cnt_d,  taken_cnt_q;

    // pc_src already excludes flushed cycles.
    always_comb begin
        instr_cnt_d  = instr_cnt_q + {31'b0, !ex.FlushE &&
                       (ex.RegWriteE || ex.MemWriteE || ex.BranchE || ex.JumpE)};
        branch_cnt_d = branch_cnt_q + {31'b0, !ex.FlushE && ex.BranchE};
        taken_cnt_d  = taken_cnt_q + {31'b0, pc_src && ex.BranchE};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_cnt_q  <= '0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else begin
            instr_cnt_q  <= instr_cnt_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
        end
    end

    assign InstrCntE  = instr_cnt_q;
    assign BranchCntE = branch_cnt_q;
    assign TakenCntE  = taken_cnt_q;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: reset, ALU ops, forwarding,
// branches, jumps, flush and back-to-back MEM forwarding.
module tb_execute_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    execute_stage_if ex_bus ();

`ifdef EX_PERF_CNT_EN
    logic [31:0] instr_cnt, branch_cnt, taken_cnt;
`endif

    execute_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex         (ex_bus)
`ifdef EX_PERF_CNT_EN
        ,
        .InstrCntE  (instr_cnt),
        .BranchCntE (branch_cnt),
        .TakenCntE  (taken_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        ex_bus.RegWriteE   = 1'b0;
        ex_bus.MemWriteE   = 1'b0;
        ex_bus.JumpE       = 1'b0;
        ex_bus.BranchE     = 1'b0;
        ex_bus.ALUSrcE     = 1'b0;
        ex_bus.JalrE       = 1'b0;
        ex_bus.ResultSrcE  = 2'b00;
        ex_bus.ALUControlE = 4'b0000;
        ex_bus.funct3E     = 3'b000;
        ex_bus.PCE         = 32'h0;
        ex_bus.ImmExtE     = 32'h0;
        ex_bus.PCPlus4E    = 32'h0;
        ex_bus.RD1E        = 32'h0;
        ex_bus.RD2E        = 32'h0;
        ex_bus.RdE         = 5'd0;
        ex_bus.ForwardAE   = 2'b00;
        ex_bus.ForwardBE   = 2'b00;
        ex_bus.ResultW     = 32'h0;
        ex_bus.FlushE      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        ex_bus.RegWriteE  = 1'b1;
        ex_bus.MemWriteE  = 1'b1;
        ex_bus.ResultSrcE = 2'b10;
        ex_bus.RD1E       = 32'h1234;
        ex_bus.PCPlus4E   = 32'h44;
        ex_bus.RdE        = 5'd7;
        ex_bus.funct3E    = 3'b010;
        tick();
        tick();
        total++;
        if (ex_bus.RegWriteM !== 1'b0 || ex_bus.MemWriteM !== 1'b0 || ex_bus.ResultSrcM !== 2'b00) begin
            bad++;
            $display("FAIL reset_ctrl: got rw=%b mw=%b rs=%b, want 0 0 00",
                     ex_bus.RegWriteM, ex_bus.MemWriteM, ex_bus.ResultSrcM);
        end
        total++;
        if (ex_bus.ALUResultM !== 32'h0 || ex_bus.WriteDataM !== 32'h0 || ex_bus.PCPlus4M !== 32'h0 ||
            ex_bus.RdM !== 5'd0 || ex_bus.funct3M !== 3'b000) begin
            bad++;
            $display("FAIL reset_data: got alu=%h wd=%h pc4=%h rd=%0d f3=%b, want all 0",
                     ex_bus.ALUResultM, ex_bus.WriteDataM, ex_bus.PCPlus4M, ex_bus.RdM, ex_bus.funct3M);
        end
`ifdef EX_PERF_CNT_EN
        total++;
        if (instr_cnt !== 32'h0 || branch_cnt !== 32'h0 || taken_cnt !== 32'h0) begin
            bad++;
            $display("FAIL reset_cnt: got %h %h %h, want 0 0 0", instr_cnt, branch_cnt, taken_cnt);
        end
`endif
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_add();
        clear_inputs();
        ex_bus.RD1E        = 32'd5;
        ex_bus.RD2E        = 32'd7;
        ex_bus.ALUControlE = 4'b0000;
        ex_bus.RdE         = 5'd3;
        ex_bus.RegWriteE   = 1'b1;
        ex_bus.ResultSrcE  = 2'b01;
        ex_bus.funct3E     = 3'b010;
        tick();
        total++;
        if (ex_bus.ALUResultM !== 32'd12 || ex_bus.RdM !== 5'd3 || ex_bus.RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL add: got alu=%0d rd=%0d rw=%b, want 12 3 1",
                     ex_bus.ALUResultM, ex_bus.RdM, ex_bus.RegWriteM);
        end
        total++;
        if (ex_bus.WriteDataM !== 32'd7 || ex_bus.ResultSrcM !== 2'b01 || ex_bus.funct3M !== 3'b010) begin
            bad++;
            $display("FAIL add_fields: got wd=%0d rs=%b f3=%b, want 7 01 010",
                     ex_bus.WriteDataM, ex_bus.ResultSrcM, ex_bus.funct3M);
        end
        // Rd = x0 passes through untouched.
        ex_bus.RdE = 5'd0;
        tick();
        total++;
        if (ex_bus.RdM !== 5'd0 || ex_bus.RegWriteM !== 1'b1) begin
            bad++;
            $display("FAIL rd_x0: got rd=%0d rw=%b, want 0 1", ex_bus.RdM, ex_bus.RegWriteM);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        ex_bus.RD1E = 32'h10;
        tick();
        total++;
        if (ex_bus.ALUResultM !== 32'h10) begin
            bad++;
            $display("FAIL fwd_setup: got %h, want 00000010", ex_bus.ALUResultM);
        end
        ex_bus.ForwardAE = 2'b10;
        ex_bus.RD1E      = 32'hDEAD;
        ex_bus.ImmExtE   = 32'h4;
        ex_bus.ALUSrcE   = 1'b1;
        ex_bus.ForwardBE = 2'b01;
        ex_bus.ResultW   = 32'h55;
        tick();
        total++;
        if (ex_bus.ALUResultM !== 32'h14) begin
            bad++;
            $display("FAIL fwd_mem: got %h, want 00000014", ex_bus.ALUResultM);
        end
        total++;
        if (ex_bus.WriteDataM !== 32'h55) begin
            bad++;
            $display("FAIL fwd_wb: got %h, want 00000055", ex_bus.WriteDataM);
        end
        ex_bus.ForwardAE = 2'b11;
        ex_bus.ForwardBE = 2'b11;
        ex_bus.RD1E      = 32'h100;
        ex_bus.RD2E      = 32'h77;
        tick();
        total++;
        if (ex_bus.ALUResultM !== 32'h104 || ex_bus.WriteDataM !== 32'h77) begin
            bad++;
            $display("FAIL fwd_11: got alu=%h wd=%h, want 00000104 00000077",
                     ex_bus.ALUResultM, ex_bus.WriteDataM);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expect_v;
        clear_inputs();
        ex_bus.RD1E    = 32'h100;
        ex_bus.ALUSrcE = 1'b1;
        ex_bus.ImmExtE = 32'h0;
        tick();
        expect_v = 32'h100;
        ex_bus.ForwardAE = 2'b10;
        ex_bus.RD1E      = 32'hBAD0;
        ex_bus.ImmExtE   = 32'h1;
        for (int i = 0; i < 3; i++) begin
            expect_v = expect_v + 32'h1;
            tick();
            total++;
            if (ex_bus.ALUResultM !== expect_v) begin
                bad++;
                $display("FAIL b2b_%0d: got %h, want %h", i, ex_bus.ALUResultM, expect_v);
            end
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops [13] = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
                                  4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1111, 4'b1011, 4'b0000};
        logic [31:0] a_v [13] = '{32'd3, 32'hF0F0, 32'hF0F0, 32'hFFFF, 32'hFFFFFFFF, 32'd1,
                                  32'd1, 32'h80000000, 32'h80000000, 32'h0, 32'd5, 32'd5, 32'hFFFFFFFF};
        logic [31:0] b_v [13] = '{32'd5, 32'hFF00, 32'h0F0F, 32'h0F0F, 32'd1, 32'hFFFFFFFF,
                                  32'h21, 32'h1F, 32'h3F, 32'hABCDE000, 32'd7, 32'd7, 32'd2};
        logic [31:0] e_v [13] = '{32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'hF0F0, 32'd1, 32'd1,
                                  32'd2, 32'd1, 32'hFFFFFFFF, 32'hABCDE000, 32'd0, 32'd0, 32'd1};
        clear_inputs();
        for (int i = 0; i < 13; i++) begin
            ex_bus.ALUControlE = ops[i];
            ex_bus.RD1E        = a_v[i];
            ex_bus.RD2E        = b_v[i];
            tick();
            total++;
            if (ex_bus.ALUResultM !== e_v[i]) begin
                bad++;
                $display("FAIL alu_op%b: a=%h b=%h got %h, want %h",
                         ops[i], a_v[i], b_v[i], ex_bus.ALUResultM, e_v[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3  [7] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000, 3'b010};
        logic       exp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        clear_inputs();
        ex_bus.BranchE = 1'b1;
        ex_bus.RD1E    = 32'hFFFFFFFF;
        ex_bus.RD2E    = 32'h1;
        ex_bus.ALUSrcE = 1'b1;
        ex_bus.PCE     = 32'h100;
        ex_bus.ImmExtE = 32'hFFFFFFF8;
        for (int i = 0; i < 7; i++) begin
            ex_bus.funct3E = f3[i];
            #1;
            total++;
            if (ex_bus.PCSrcE !== exp[i]) begin
                bad++;
                $display("FAIL branch_f3_%b: got %b, want %b", f3[i], ex_bus.PCSrcE, exp[i]);
            end
        end
        ex_bus.funct3E = 3'b100;
        #1;
        total++;
        if (ex_bus.PCTargetE !== 32'hF8) begin
            bad++;
            $display("FAIL branch_target: got %h, want 000000f8", ex_bus.PCTargetE);
        end
        ex_bus.BranchE = 1'b0;
        #1;
        total++;
        if (ex_bus.PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL branch_off: got %b, want 0", ex_bus.PCSrcE);
        end
        tick();
    endtask

    task automatic test_jump();
        clear_inputs();
        ex_bus.JumpE     = 1'b1;
        ex_bus.JalrE     = 1'b1;
        ex_bus.RD1E      = 32'h203;
        ex_bus.ImmExtE   = 32'h2;
        ex_bus.PCE       = 32'h100;
        ex_bus.PCPlus4E  = 32'h1234;
        ex_bus.RegWriteE = 1'b1;
        ex_bus.ResultSrcE = 2'b10;
        #1;
        total++;
        if (ex_bus.PCSrcE !== 1'b1 || ex_bus.PCTargetE !== 32'h204) begin
            bad++;
            $display("FAIL jalr: got src=%b tgt=%h, want 1 00000204", ex_bus.PCSrcE, ex_bus.PCTargetE);
        end
        tick();
        total++;
        if (ex_bus.PCPlus4M !== 32'h1234 || ex_bus.ResultSrcM !== 2'b10) begin
            bad++;
            $display("FAIL jalr_pc4: got pc4=%h rs=%b, want 00001234 10", ex_bus.PCPlus4M, ex_bus.ResultSrcM);
        end
        ex_bus.JalrE = 1'b0;
        #1;
        total++;
        if (ex_bus.PCSrcE !== 1'b1 || ex_bus.PCTargetE !== 32'h102) begin
            bad++;
            $display("FAIL jal: got src=%b tgt=%h, want 1 00000102", ex_bus.PCSrcE, ex_bus.PCTargetE);
        end
        tick();
    endtask

    task automatic test_flush();
        clear_inputs();
        ex_bus.BranchE   = 1'b1;
        ex_bus.funct3E   = 3'b100;
        ex_bus.RD1E      = 32'hFFFFFFFF;
        ex_bus.RD2E      = 32'h1;
        ex_bus.PCE       = 32'h100;
        ex_bus.ImmExtE   = 32'hFFFFFFF8;
        ex_bus.RegWriteE = 1'b1;
        ex_bus.MemWriteE = 1'b1;
        ex_bus.FlushE    = 1'b1;
        #1;
        total++;
        if (ex_bus.PCSrcE !== 1'b0) begin
            bad++;
            $display("FAIL flush_pcsrc: got %b, want 0", ex_bus.PCSrcE);
        end
        tick();
        total++;
        if (ex_bus.RegWriteM !== 1'b0 || ex_bus.MemWriteM !== 1'b0) begin
            bad++;
            $display("FAIL flush_bubble: got rw=%b mw=%b, want 0 0", ex_bus.RegWriteM, ex_bus.MemWriteM);
        end
        ex_bus.FlushE = 1'b0;
        tick();
        total++;
        if (ex_bus.RegWriteM !== 1'b1 || ex_bus.MemWriteM !== 1'b1) begin
            bad++;
            $display("FAIL unflush: got rw=%b mw=%b, want 1 1", ex_bus.RegWriteM, ex_bus.MemWriteM);
        end
        rst = 1'b1;
        ex_bus.PCPlus4E = 32'h88;
        ex_bus.RdE      = 5'd9;
        #1;
        total++;
        if (ex_bus.PCSrcE !== 1'b1) begin
            bad++;
            $display("FAIL rst_pcsrc: got %b, want 1", ex_bus.PCSrcE);
        end
        tick();
        total++;
        if (ex_bus.RegWriteM !== 1'b0 || ex_bus.MemWriteM !== 1'b0 || ex_bus.ALUResultM !== 32'h0 ||
            ex_bus.WriteDataM !== 32'h0 || ex_bus.PCPlus4M !== 32'h0 || ex_bus.RdM !== 5'd0 ||
            ex_bus.funct3M !== 3'b000 || ex_bus.ResultSrcM !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid: got rw=%b mw=%b alu=%h wd=%h pc4=%h rd=%0d f3=%b, want all 0",
                     ex_bus.RegWriteM, ex_bus.MemWriteM, ex_bus.ALUResultM, ex_bus.WriteDataM,
                     ex_bus.PCPlus4M, ex_bus.RdM, ex_bus.funct3M);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clear_inputs();
        test_reset();
        test_add();
        test_forward();
        test_back_to_back();
        test_alu();
        test_branch();
        test_jump();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32I execute stage, directly downstream of the ID/EX pipeline register.
- Applies operand forwarding, runs the ALU, resolves branches and jumps, computes the redirect target, and registers results into the EX/MEM pipeline register.
- PCSrcE and PCTargetE go combinationally to fetch; all M-suffixed outputs feed the memory stage.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE  in  1 each  control from ID/EX
ResultSrcE  in  2  writeback select
ALUControlE  in  4  ALU opcode
funct3E  in  3  branch condition / memory size
PCE, ImmExtE, PCPlus4E, RD1E, RD2E  in  32 each  ID/EX data
RdE  in  5  destination register
ForwardAE, ForwardBE  in  2 each  forwarding selects from hazard unit
ResultW  in  32  writeback-stage result
FlushE  in  1  squash the instruction currently in EX
PCSrcE  out  1  redirect fetch (combinational)
PCTargetE  out  32  redirect address (combinational)
RegWriteM, MemWriteM  out  1 each  registered control
ResultSrcM  out  2  registered writeback select
ALUResultM, WriteDataM, PCPlus4M  out  32 each  registered data
RdM  out  5  registered destination
funct3M  out  3  registered funct3

Behaviour:
- Forwarding, SrcA:
  - ForwardAE 00 → RD1E; 01 → ResultW; 10 → ALUResultM (internal register value); 11 → RD1E.
- Forwarding, SrcB:
  - ForwardBE selects FwdB the same way, starting from RD2E.
  - SrcB = ALUSrcE ? ImmExtE : FwdB.
- ALU opcodes (ALUControlE):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount is SrcB[4:0].
  - 1010 PASSB (LUI).
  - All other codes → 0.
  - Arithmetic is modulo 2^32.
- Branch condition (taken), uses SrcA vs FwdB regardless of ALUSrcE:
  - funct3 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010 and 011 → not taken.
- PCTargetE = JalrE ? ((SrcA + ImmExtE) & ~1) : (PCE + ImmExtE).
- PCSrcE = !FlushE && ((BranchE && taken) || JumpE). Zero cycles of latency.
- EX/MEM register, posedge clk, priority rst > FlushE > load:
  - rst: every M-suffixed output is 0.
  - FlushE=1: RegWriteM=0 and MemWriteM=0 (bubble). Data fields load normally but are don't-care.
  - Otherwise: ALUResultM = ALU result; WriteDataM = FwdB; RegWriteM, MemWriteM, ResultSrcM, PCPlus4M, RdM, funct3M copied from their E-suffixed inputs.
- Latency: 1 cycle from E inputs to M outputs. No stall; the register loads every cycle.
- Back-to-back dependency: ForwardAE=10 must return the value registered on the previous edge.
- Rd = x0 handling: RdE=0 is passed through unchanged. Suppressing the x0 write is writeback's job.
- Reset mid-instruction: the in-flight EX instruction is lost. PCSrcE stays combinational and is not gated by rst.

Optional Feature:
EX_PERF_CNT_EN
- Defined:
  - Three 32-bit wrapping counters, cleared by rst, read-only outputs: InstrCntE, BranchCntE, TakenCntE.
  - Each increments once per clock when FlushE=0:
    - InstrCntE: every cycle where RegWriteE|MemWriteE|BranchE|JumpE.
    - BranchCntE: every BranchE.
    - TakenCntE: every cycle where PCSrcE=1 and BranchE=1.
- Undefined: no counters and no counter ports; behaviour otherwise identical.

Decomposition:
- Shared package rv32_pkg:
  - ALU opcode constants (ALU_ADD…ALU_PASSB).
  - Branch funct3 constants.
  - Forward-select constants (FWD_RF, FWD_WB, FWD_MEM).
  - ResultSrc encodings.
- One sub-module: alu (combinational; SrcA, SrcB, ALUControl → result). execute_stage instantiates it and owns the forwarding muxes, branch logic and EX/MEM register.

Test Plan:
1. ADD: RD1E=5, RD2E=7, ALUSrcE=0, ALUControlE=0000, RdE=3, RegWriteE=1 → next edge ALUResultM=12, RdM=3, RegWriteM=1.
2. Forwarding: cycle 1 produces ALUResultM=0x10. Cycle 2 has ForwardAE=10, RD1E=0xDEAD, ImmExtE=4, ALUSrcE=1, ADD → ALUResultM=0x14. With ForwardBE=01 and ResultW=0x55, WriteDataM=0x55.
3. BLT: SrcA=0xFFFFFFFF, FwdB=1, funct3=100, BranchE=1, PCE=0x100, ImmExtE=0xFFFFFFF8 → PCSrcE=1, PCTargetE=0xF8. funct3=110 with the same operands → PCSrcE=0.
4. JALR: JumpE=1, JalrE=1, SrcA=0x203, ImmExtE=2 → PCTargetE=0x204, PCSrcE=1, next PCPlus4M=PCPlus4E.
5. Flush: same as test 3 with FlushE=1 → PCSrcE=0, next RegWriteM=0, MemWriteM=0. Assert rst with valid inputs → all M outputs 0 next edge.
6. SRA: SrcA=0x80000000, SrcB=0x3F → 0xFFFFFFFF (shift amount 31). SLTU: 1 vs 0xFFFFFFFF → 1. Undefined opcode 1111 → 0.
